// File: rtl/spcpu_mem_bridge.sv
// spcpu data-port bridge to an 8-bit SRAM with fixed wait states.
// 16-bit accesses are split into two big-endian byte phases (addr, then addr+1).
module spcpu_mem_bridge #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic              cpu_acc_sz,
    input  logic [15:0]       cpu_wdata,
    output logic [15:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [15:0]       acc_count
);

    localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        BYTE0,
        BYTE1,
        DONE
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic              sz_q;
    logic [7:0]        wlo_q;
    logic [3:0]        wait_q;
    logic [7:0]        byte0_q;
    logic [15:0]       rdata_q;
    logic              ready_q;
    logic              en_q;
    logic              mwe_q;
    logic [ADDR_W-1:0] maddr_q;
    logic [7:0]        mwdata_q;
    logic [15:0]       acc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            sz_q     <= 1'b0;
            wlo_q    <= '0;
            wait_q   <= '0;
            byte0_q  <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            en_q     <= 1'b0;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            acc_q    <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        addr_q   <= cpu_addr;
                        we_q     <= cpu_we;
                        sz_q     <= cpu_acc_sz;
                        wlo_q    <= cpu_wdata[7:0];
                        wait_q   <= WAIT_LD;
                        en_q     <= 1'b1;
                        mwe_q    <= cpu_we;
                        maddr_q  <= cpu_addr;
                        mwdata_q <= cpu_acc_sz ? cpu_wdata[15:8] : cpu_wdata[7:0];
                        state_q  <= BYTE0;
                    end
                end
                BYTE0: begin
                    if (wait_q != 4'd0) begin
                        wait_q <= wait_q - 4'd1;
                    end else if (sz_q) begin
                        // mem_en stays high straight into the second byte
                        byte0_q  <= mem_rdata;
                        wait_q   <= WAIT_LD;
                        maddr_q  <= addr_q + ADDR_W'(1);
                        mwdata_q <= wlo_q;
                        state_q  <= BYTE1;
                    end else begin
                        en_q    <= 1'b0;
                        mwe_q   <= 1'b0;
                        ready_q <= 1'b1;
                        acc_q   <= acc_q + 16'd1;
                        if (!we_q) rdata_q <= {8'h00, mem_rdata};
                        state_q <= DONE;
                    end
                end
                BYTE1: begin
                    if (wait_q != 4'd0) begin
                        wait_q <= wait_q - 4'd1;
                    end else begin
                        en_q    <= 1'b0;
                        mwe_q   <= 1'b0;
                        ready_q <= 1'b1;
                        acc_q   <= acc_q + 16'd1;
                        if (!we_q) rdata_q <= {byte0_q, mem_rdata};
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu_busy  = (state_q != IDLE);
    assign cpu_rdata = rdata_q;
    assign cpu_ready = ready_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = mwdata_q;
    assign mem_en    = en_q;
    assign mem_we    = mwe_q;
    assign acc_count = acc_q;

endmodule

// File: tb/tb_spcpu_mem_bridge.sv
// Bench for spcpu_mem_bridge: three instances (W = 0, 1, 2), each on its own SRAM model,
// driven by a directed vector table, hand sequences and random accesses.
module tb_spcpu_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        req   [3];
    logic [15:0] addr  [3];
    logic        we    [3];
    logic        sz    [3];
    logic [15:0] wd    [3];
    logic [15:0] rdata [3];
    logic        ready [3];
    logic        busy  [3];
    logic [15:0] maddr [3];
    logic [7:0]  mwd   [3];
    logic [7:0]  mrd   [3];
    logic        men   [3];
    logic        mwe   [3];
    logic [15:0] acc   [3];

    bit   [7:0]  sram    [3][65536];
    bit   [7:0]  ref_mem [3][65536];
    logic [15:0] exp_acc [3];
    logic [15:0] exp_rd  [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        spcpu_mem_bridge #(.ADDR_W(16), .WAIT_STATES(g)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .cpu_req    (req[g]),
            .cpu_addr   (addr[g]),
            .cpu_we     (we[g]),
            .cpu_acc_sz (sz[g]),
            .cpu_wdata  (wd[g]),
            .cpu_rdata  (rdata[g]),
            .cpu_ready  (ready[g]),
            .cpu_busy   (busy[g]),
            .mem_addr   (maddr[g]),
            .mem_wdata  (mwd[g]),
            .mem_rdata  (mrd[g]),
            .mem_en     (men[g]),
            .mem_we     (mwe[g]),
            .acc_count  (acc[g])
        );
        assign mrd[g] = sram[g][maddr[g]];
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++)
            if (men[k] === 1'b1 && mwe[k] === 1'b1) sram[k][maddr[k]] <= mwd[k];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One complete access on instance k; the memory-side sequence is derived from W = k.
    task automatic run_acc(input int k, input bit w, input bit s, input logic [15:0] a,
                           input logic [15:0] d, input logic [15:0] erd, input int elat);
        int          ph;
        int          got;
        int          pulses;
        bit          seq_ok;
        logic [15:0] a1;
        logic [15:0] ea;
        logic [7:0]  ewd;
        logic [15:0] rd_done;
        logic [15:0] rd_after;
        logic [15:0] acc_done;
        logic [15:0] acc_next;
        ph = s ? 2 * (k + 1) : k + 1;
        got = -1; pulses = 0; seq_ok = 1'b1;
        a1 = a + 16'd1;
        rd_done = '0; rd_after = '0; acc_done = '0;
        @(negedge clk);
        req[k] = 1'b1; addr[k] = a; we[k] = w; sz[k] = s; wd[k] = d;
        for (int n = 1; n <= elat + 2; n++) begin
            @(negedge clk);
            if (n == 1) begin
                req[k] = 1'b0; addr[k] = ~a; we[k] = ~w; sz[k] = ~s; wd[k] = ~d;
            end
            ea  = (n <= k + 1) ? a : a1;
            ewd = (s && n <= k + 1) ? d[15:8] : d[7:0];
            if (men[k] !== (n <= ph)) seq_ok = 1'b0;
            if (n <= ph && (maddr[k] !== ea || mwe[k] !== w || mwd[k] !== ewd)) seq_ok = 1'b0;
            if (n > ph && mwe[k] !== 1'b0) seq_ok = 1'b0;
            if (busy[k] !== (n <= ph + 1)) seq_ok = 1'b0;
            if (ready[k] === 1'b1) begin
                pulses++;
                if (got < 0) begin
                    got = n; rd_done = rdata[k]; acc_done = acc[k];
                end
            end
            if (n == elat + 1) rd_after = rdata[k];
        end
        acc_next = exp_acc[k] + 16'd1;
        check($sformatf("k%0d ready_latency", k), got, elat);
        check($sformatf("k%0d ready_pulses", k), pulses, 1);
        check($sformatf("k%0d rdata", k), rd_done, erd);
        check($sformatf("k%0d rdata_hold", k), rd_after, erd);
        check($sformatf("k%0d acc_count", k), acc_done, acc_next);
        check($sformatf("k%0d mem_sequence a=%h", k, a), seq_ok, 1);
        exp_acc[k] = acc_next;
        if (w) begin
            ref_mem[k][a] = s ? d[15:8] : d[7:0];
            if (s) ref_mem[k][a1] = d[7:0];
        end else begin
            exp_rd[k] = erd;
        end
    endtask

    typedef struct {
        int          k;
        bit          w;
        bit          s;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] erd;
        int          lat;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int          base;
        bit          ok;
        bit          w, s;
        logic [15:0] a, a1, d, erd;
        int          mism;

        tbl[0]  = '{1, 1'b1, 1'b1, 16'h0010, 16'hABCD, 16'h0000, 5};
        tbl[1]  = '{1, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'hABCD, 5};
        tbl[2]  = '{0, 1'b1, 1'b0, 16'h0020, 16'h1234, 16'h0000, 2};
        tbl[3]  = '{0, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0034, 2};
        tbl[4]  = '{0, 1'b0, 1'b0, 16'h0021, 16'h0000, 16'h0000, 2};
        tbl[5]  = '{2, 1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 16'h0000, 7};
        tbl[6]  = '{2, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h00BE, 4};
        tbl[7]  = '{2, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h00EF, 4};
        tbl[8]  = '{2, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'hBEEF, 7};
        tbl[9]  = '{1, 1'b1, 1'b0, 16'h0011, 16'hFF77, 16'hABCD, 3};
        tbl[10] = '{1, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'hAB77, 5};
        tbl[11] = '{1, 1'b0, 1'b1, 16'h000F, 16'h0000, 16'h00AB, 5};

        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; addr[k] = '0; we[k] = 1'b0; sz[k] = 1'b0; wd[k] = '0;
            exp_acc[k] = '0; exp_rd[k] = '0;
        end

        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("k%0d reset rdata/acc", k), {rdata[k], acc[k]}, 32'h0);
            check($sformatf("k%0d reset ctrl/mem", k),
                  {ready[k], busy[k], men[k], mwe[k], mwd[k], maddr[k]}, 32'h0);
        end
        reset = 1'b0;

        foreach (tbl[i])
            run_acc(tbl[i].k, tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].erd, tbl[i].lat);

        check("sram0[0020]", sram[0][16'h0020], 8'h34);
        check("sram0[0021]", sram[0][16'h0021], 8'h00);
        check("sram2[FFFF]", sram[2][16'hFFFF], 8'hBE);
        check("sram2[0000]", sram[2][16'h0000], 8'hEF);

        // req held high on W=0: new accesses only in cycles 0, 3, 6
        base = exp_acc[0];
        ok = 1'b1;
        for (int n = 0; n <= 9; n++) begin
            @(negedge clk);
            if (n >= 1) begin
                if (men[0] !== (n % 3 == 1)) ok = 1'b0;
                if (ready[0] !== (n % 3 == 2)) ok = 1'b0;
                if (n % 3 == 1) check($sformatf("b2b mem_addr c%0d", n), maddr[0], 16'h0040 + 16'(n - 1));
                if (n % 3 == 2) check($sformatf("b2b acc_count c%0d", n), acc[0], 16'(base + n / 3 + 1));
            end
            if (n <= 8) begin
                req[0] = 1'b1; we[0] = 1'b0; sz[0] = 1'b0; addr[0] = 16'h0040 + 16'(n);
            end else begin
                req[0] = 1'b0;
            end
        end
        check("b2b en/ready pattern", ok, 1);
        exp_acc[0] = 16'(base + 3);
        exp_rd[0]  = {8'h00, ref_mem[0][16'h0046]};
        repeat (2) @(negedge clk);

        // reset held 3 cycles in BYTE1 of a 16-bit read on W=1
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; sz[1] = 1'b1; addr[1] = 16'h0010;
        @(negedge clk);
        req[1] = 1'b0;
        repeat (2) @(negedge clk);
        check("rst pre BYTE1 mem_addr", maddr[1], 16'h0011);
        reset = 1'b1;
        @(negedge clk);
        check("rst en/we/busy/ready", {men[1], mwe[1], busy[1], ready[1]}, 4'h0);
        check("rst acc/rdata", {acc[1], rdata[1]}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ok = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (ready[1] !== 1'b0 || men[1] !== 1'b0 || busy[1] !== 1'b0) ok = 1'b0;
        end
        check("rst no resumed activity", ok, 1);
        for (int k = 0; k < 3; k++) begin
            exp_acc[k] = '0; exp_rd[k] = '0;
        end

        // acc_count preload to just below wrap, then two completions
        @(negedge clk);
        force g_dut[0].u_dut.acc_q = 16'hFFFE;
        @(negedge clk);
        release g_dut[0].u_dut.acc_q;
        exp_acc[0] = 16'hFFFE;
        run_acc(0, 1'b0, 1'b0, 16'h0020, 16'h0000, {8'h00, ref_mem[0][16'h0020]}, 2);
        run_acc(0, 1'b0, 1'b0, 16'h0021, 16'h0000, {8'h00, ref_mem[0][16'h0021]}, 2);

        for (int it = 0; it < 30; it++) begin
            for (int k = 0; k < 3; k++) begin
                w  = 1'($urandom_range(0, 1));
                s  = 1'($urandom_range(0, 1));
                a  = 16'hFFF8 + 16'($urandom_range(0, 15));
                a1 = a + 16'd1;
                d  = 16'($urandom);
                if (w)      erd = exp_rd[k];
                else if (s) erd = {ref_mem[k][a], ref_mem[k][a1]};
                else        erd = {8'h00, ref_mem[k][a]};
                run_acc(k, w, s, a, d, erd, s ? 2 * k + 3 : k + 2);
            end
        end

        for (int k = 0; k < 3; k++) begin
            mism = 0;
            for (int i = 0; i < 65536; i++)
                if (sram[k][i] != ref_mem[k][i]) mism++;
            check($sformatf("k%0d sram image", k), mism, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
